// File: rtl/dekatron_counter_n_if.sv
// Handshake and data bundle for the N-digit dekatron counter.
// The master drives requests and load data; the slave reports the count and status pulses.
interface dekatron_counter_n_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  request;
  logic                  reverse;
  logic                  set;
  logic                  wrap;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [10*DIGITS-1:0]  out_dek;
  logic                  zero;
  logic                  carry;
  logic                  saturated;

  modport master (
    output request, reverse, set, wrap, in_bcd,
    input  ready, out_bcd, out_dek, zero, carry, saturated
  );

  modport slave (
    input  request, reverse, set, wrap, in_bcd,
    output ready, out_bcd, out_dek, zero, carry, saturated
  );
endinterface

// File: rtl/dekatron_counter_n.sv
// N-digit decade up/down counter held as one-hot dekatron digits, with a settle-time
// handshake, selectable wrap/saturate at programmable limits, and BCD readout.
module dekatron_counter_n #(
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned MAX_VALUE     = 255,
  parameter int unsigned MIN_VALUE     = 0,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dekatron_counter_n_if.slave  ctr_io
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned DekW = 10 * DIGITS;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  function automatic logic [BcdW-1:0] int_to_bcd(input int unsigned v);
    logic [BcdW-1:0] r;
    int unsigned     t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [DekW-1:0] bcd_to_dek(input logic [BcdW-1:0] b);
    logic [DekW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      for (int j = 0; j < 10; j++) begin
        r[10*i + j] = (b[4*i +: 4] == 4'(j));
      end
    end
    return r;
  endfunction

  function automatic logic [BcdW-1:0] dek_to_bcd(input logic [DekW-1:0] d);
    logic [BcdW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      for (int j = 0; j < 10; j++) begin
        if (d[10*i + j]) r[4*i +: 4] = r[4*i +: 4] | 4'(j);
      end
    end
    return r;
  endfunction

  localparam logic [BcdW-1:0] MinBcd = int_to_bcd(MIN_VALUE);
  localparam logic [BcdW-1:0] MaxBcd = int_to_bcd(MAX_VALUE);
  localparam logic [DekW-1:0] MinDek = bcd_to_dek(MinBcd);
  localparam logic [DekW-1:0] MaxDek = bcd_to_dek(MaxBcd);

  typedef enum logic [0:0] {StIdle, StSettle} state_e;

  state_e          state_q;
  logic            ready_q;
  logic [CntW-1:0] cnt_q;
  logic [DekW-1:0] dek_q, dek_d;
  logic            carry_q, carry_d;
  logic            sat_q, sat_d;

  logic [BcdW-1:0] cur_bcd;
  logic [BcdW-1:0] san_bcd;
  logic [BcdW-1:0] load_bcd;
  logic [DekW-1:0] step_dek;
  logic            ripple;
  logic            accept;
  logic            at_limit;

  assign cur_bcd = dek_to_bcd(dek_q);
  assign accept  = ready_q & (ctr_io.set | ctr_io.request);

  // Valid BCD vectors order the same way as their decimal values, so plain compares clamp.
  always_comb begin
    san_bcd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      san_bcd[4*i +: 4] = (ctr_io.in_bcd[4*i +: 4] > 4'd9) ? 4'd0 : ctr_io.in_bcd[4*i +: 4];
    end
    if ((MIN_VALUE > 0) && (san_bcd < MinBcd)) begin
      load_bcd = MinBcd;
    end else if (san_bcd > MaxBcd) begin
      load_bcd = MaxBcd;
    end else begin
      load_bcd = san_bcd;
    end
  end

  // Each digit rotates one position when every lower digit sits at 9 (up) or 0 (down).
  always_comb begin
    step_dek = dek_q;
    ripple   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (ripple) begin
        step_dek[10*i +: 10] = ctr_io.reverse ? {dek_q[10*i], dek_q[10*i+1 +: 9]}
                                              : {dek_q[10*i +: 9], dek_q[10*i+9]};
      end
      ripple = ripple & (ctr_io.reverse ? dek_q[10*i] : dek_q[10*i+9]);
    end
  end

  assign at_limit = ctr_io.reverse ? (cur_bcd == MinBcd) : (cur_bcd == MaxBcd);

  always_comb begin
    dek_d   = dek_q;
    carry_d = 1'b0;
    sat_d   = 1'b0;
    if (accept) begin
      if (ctr_io.set) begin
        dek_d = bcd_to_dek(load_bcd);
      end else if (at_limit) begin
        if (ctr_io.wrap) begin
          dek_d   = ctr_io.reverse ? MaxDek : MinDek;
          carry_d = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end else begin
        dek_d = step_dek;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      cnt_q   <= '0;
      dek_q   <= MinDek;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      dek_q   <= dek_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      case (state_q)
        StIdle: begin
          if (accept && (SETTLE_CYCLES != 0)) begin
            state_q <= StSettle;
            ready_q <= 1'b0;
            cnt_q   <= CntW'(SETTLE_CYCLES - 1);
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ctr_io.ready     = ready_q;
  assign ctr_io.out_bcd   = cur_bcd;
  assign ctr_io.out_dek   = dek_q;
  assign ctr_io.zero      = (cur_bcd == '0);
  assign ctr_io.carry     = carry_q;
  assign ctr_io.saturated = sat_q;

endmodule

// File: tb/tb_dekatron_counter_n.sv
// Directed plus randomized bench for the dekatron counter: a 3-digit 0..255 instance with settle
// time and a 4-digit 100..9000 instance without, both checked against an integer model.
module tb_dekatron_counter_n;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mv_a = 0;
  int   mv_b = 100;

  always #5 clk = ~clk;

  dekatron_counter_n_if #(.DIGITS(3)) a_if ();
  dekatron_counter_n_if #(.DIGITS(4)) b_if ();

  dekatron_counter_n #(
    .DIGITS(3), .MAX_VALUE(255), .MIN_VALUE(0), .SETTLE_CYCLES(2)
  ) u_dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .ctr_io(a_if)
  );

  dekatron_counter_n #(
    .DIGITS(4), .MAX_VALUE(9000), .MIN_VALUE(100), .SETTLE_CYCLES(0)
  ) u_dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .ctr_io(b_if)
  );

  function automatic logic [15:0] bcd_of(input int v, input int digits);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [39:0] dek_of(input int v, input int digits);
    logic [39:0] r = '0;
    int t = v;
    for (int i = 0; i < digits; i++) begin
      r[10*i + (t % 10)] = 1'b1;
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_val(input logic [15:0] inb, input int digits, input int mn,
                                  input int mx);
    int v = 0;
    int mult = 1;
    int d;
    for (int i = 0; i < digits; i++) begin
      d = int'(inb[4*i +: 4]);
      if (d > 9) d = 0;
      v += d * mult;
      mult *= 10;
    end
    if (v < mn) v = mn;
    if (v > mx) v = mx;
    return v;
  endfunction

  function automatic void model_op(input bit s, input bit r, input bit rev, input bit w,
                                   input logic [15:0] inb, input int digits, input int mn,
                                   input int mx, input int v, output int nv, output bit c,
                                   output bit sat);
    nv = v;
    c = 1'b0;
    sat = 1'b0;
    if (s) begin
      nv = load_val(inb, digits, mn, mx);
    end else if (r) begin
      if (!rev && v == mx) begin
        if (w) begin nv = mn; c = 1'b1; end else sat = 1'b1;
      end else if (rev && v == mn) begin
        if (w) begin nv = mx; c = 1'b1; end else sat = 1'b1;
      end else begin
        nv = rev ? v - 1 : v + 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input bit c, input bit s);
    chk({tag, "_out"}, a_if.out_bcd, bcd_of(mv_a, 3));
    chk({tag, "_dek"}, a_if.out_dek, dek_of(mv_a, 3));
    chk({tag, "_zero"}, a_if.zero, (mv_a == 0));
    chk({tag, "_carry"}, a_if.carry, c);
    chk({tag, "_sat"}, a_if.saturated, s);
  endtask

  task automatic check_b(input string tag, input bit c, input bit s);
    chk({tag, "_out"}, b_if.out_bcd, bcd_of(mv_b, 4));
    chk({tag, "_dek"}, b_if.out_dek, dek_of(mv_b, 4));
    chk({tag, "_zero"}, b_if.zero, (mv_b == 0));
    chk({tag, "_carry"}, b_if.carry, c);
    chk({tag, "_sat"}, b_if.saturated, s);
    chk({tag, "_rdy"}, b_if.ready, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic op_a(input bit s, input bit r, input bit rev, input bit w,
                      input logic [11:0] inb, input string tag);
    int nv;
    bit c, sat;
    for (int k = 0; k < 8 && a_if.ready !== 1'b1; k++) @(negedge clk);
    chk({tag, "_rdy_in"}, a_if.ready, 1'b1);
    a_if.set = s; a_if.request = r; a_if.reverse = rev; a_if.wrap = w; a_if.in_bcd = inb;
    @(negedge clk);
    a_if.set = 1'b0; a_if.request = 1'b0;
    model_op(s, r, rev, w, {4'h0, inb}, 3, 0, 255, mv_a, nv, c, sat);
    mv_a = nv;
    check_a(tag, c, sat);
    chk({tag, "_busy0"}, a_if.ready, 1'b0);
  endtask

  task automatic settle_a(input string tag);
    @(negedge clk);
    chk({tag, "_busy1"}, a_if.ready, 1'b0);
    chk({tag, "_pulse_clr"}, {a_if.carry, a_if.saturated}, 2'b00);
    @(negedge clk);
    chk({tag, "_rdy_back"}, a_if.ready, 1'b1);
  endtask

  initial begin
    int nv;
    bit c, sat, s, r, rev, w;
    logic [15:0] inb;

    a_if.set = 0; a_if.request = 1; a_if.reverse = 0; a_if.wrap = 0; a_if.in_bcd = '0;
    b_if.set = 0; b_if.request = 0; b_if.reverse = 0; b_if.wrap = 0; b_if.in_bcd = '0;

    // Reset with Request held high, then the first step is taken on release.
    repeat (3) @(negedge clk);
    check_a("reset", 1'b0, 1'b0);
    chk("reset_rdy", a_if.ready, 1'b1);
    rst_a = 1'b0;
    @(negedge clk);
    a_if.request = 1'b0;
    mv_a = 1;
    check_a("t1_step", 1'b0, 1'b0);
    chk("t1_busy0", a_if.ready, 1'b0);
    settle_a("t1");

    // Two-digit ripple up and borrow down.
    op_a(1, 0, 0, 0, 12'h099, "t2_set");   settle_a("t2_set");
    op_a(0, 1, 0, 0, 12'h000, "t2_up");    settle_a("t2_up");
    op_a(0, 1, 1, 0, 12'h000, "t2_dn");    settle_a("t2_dn");

    // Upper limit: wrap then saturate.
    op_a(1, 0, 0, 0, 12'h255, "t3_set");   settle_a("t3_set");
    op_a(0, 1, 0, 1, 12'h000, "t3_wrap");  settle_a("t3_wrap");
    op_a(1, 0, 0, 0, 12'h255, "t3_set2");  settle_a("t3_set2");
    op_a(0, 1, 0, 0, 12'h000, "t3_sat");   settle_a("t3_sat");

    // Lower limit wrap, then a load with an invalid nibble that also needs clamping.
    op_a(1, 0, 0, 0, 12'h000, "t4_set");   settle_a("t4_set");
    op_a(0, 1, 1, 1, 12'h000, "t4_wrap");  settle_a("t4_wrap");
    op_a(1, 0, 0, 0, 12'h9A7, "t4_clamp"); settle_a("t4_clamp");
    op_a(1, 0, 0, 0, 12'h0A7, "t4_nib");   settle_a("t4_nib");

    // Load beats step; busy requests are dropped; reset aborts settle.
    op_a(1, 1, 0, 1, 12'h123, "t5_both");
    a_if.request = 1'b1;
    @(negedge clk);
    a_if.request = 1'b0;
    check_a("t5_ignored", 1'b0, 1'b0);
    chk("t5_ign_busy", a_if.ready, 1'b0);
    @(negedge clk);
    chk("t5_ign_rdy", a_if.ready, 1'b1);
    op_a(0, 1, 0, 0, 12'h000, "t5_step");
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    mv_a = 0;
    check_a("t5_rst", 1'b0, 1'b0);
    chk("t5_rst_rdy", a_if.ready, 1'b1);

    // Randomized operations on the 3-digit counter.
    for (int n = 0; n < 60; n++) begin
      s = ($urandom_range(3) == 0);
      inb = ($urandom_range(1) == 0) ? 16'($urandom) : bcd_of($urandom_range(255), 3);
      op_a(s, ~s, 1'($urandom), 1'($urandom), inb[11:0], "rnd_a");
      settle_a("rnd_a");
    end

    // 4-digit instance: reset value, then back-to-back steps into saturation.
    @(negedge clk);
    check_b("t6_reset", 1'b0, 1'b0);
    rst_b = 1'b0;
    b_if.set = 1'b1; b_if.in_bcd = 16'h8950;
    @(negedge clk);
    b_if.set = 1'b0;
    mv_b = 8950;
    check_b("t6_set", 1'b0, 1'b0);
    b_if.request = 1'b1; b_if.reverse = 1'b0; b_if.wrap = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      model_op(0, 1, 0, 0, 16'h0, 4, 100, 9000, mv_b, nv, c, sat);
      mv_b = nv;
      check_b("t6_run", c, sat);
    end
    chk("t6_final", b_if.out_bcd, 16'h9000);
    b_if.request = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    mv_b = 100;
    check_b("t6_rst", 1'b0, 1'b0);

    // Randomized single-cycle operations on the 4-digit counter.
    for (int n = 0; n < 300; n++) begin
      s = ($urandom_range(7) == 0);
      r = ($urandom_range(3) != 0);
      rev = 1'($urandom);
      w = 1'($urandom);
      inb = ($urandom_range(1) == 0) ? 16'($urandom) : bcd_of($urandom_range(9010, 80), 4);
      b_if.set = s; b_if.request = r; b_if.reverse = rev; b_if.wrap = w; b_if.in_bcd = inb;
      @(negedge clk);
      model_op(s, r, rev, w, inb, 4, 100, 9000, mv_b, nv, c, sat);
      mv_b = nv;
      check_b("rnd_b", c, sat);
    end
    b_if.set = 1'b0; b_if.request = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
